// File: rtl/audio_pkg.sv
// audio_pkg: shared state encoding, timing defaults and sizing helper for the beep scheduler
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int UNIT_100MS = 10_000_000;
    localparam int GAP_50MS   = 5_000_000;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/beep_request_scheduler_if.sv
// beep_request_scheduler_if: request, tone and audio signals between game logic and the beep scheduler
interface beep_request_scheduler_if #(
    parameter int NUM_REQ = 4
);
    import audio_pkg::*;

    localparam int IDW = cnt_width(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [4*NUM_REQ-1:0] req_len;
    logic                 abort;
    logic [11:0]          tone_a;
    logic [11:0]          tone_b;
    logic [11:0]          audio_out;
    logic                 sound_on;
    logic [IDW-1:0]       active_id;
    logic                 busy;
    logic                 beep_done;

    modport master (
        output req, req_len, abort, tone_a, tone_b,
        input  audio_out, sound_on, active_id, busy, beep_done
    );

    modport slave (
        input  req, req_len, abort, tone_a, tone_b,
        output audio_out, sound_on, active_id, busy, beep_done
    );

endinterface

// File: rtl/beep_unit_timer.sv
// beep_unit_timer: loadable down-counter of units, each unit lasting tick_last+1 cycles
module beep_unit_timer #(
    parameter int TW = 1
) (
    input  logic          clk100M,
    input  logic          rst,
    input  logic          clear,
    input  logic          load,
    input  logic [3:0]    units,
    input  logic [TW-1:0] tick_last,
    input  logic          count_en,
    output logic          last_cycle,
    output logic          running
);

    logic [TW-1:0] tick_q, tick_d, lim_q, lim_d;
    logic [3:0]    unit_q, unit_d;
    logic          wrap;

    assign wrap       = tick_q == lim_q;
    assign last_cycle = (unit_q == 4'd1) && wrap;
    assign running    = unit_q != 4'd0;

    // load takes priority over counting so a phase can start on the last cycle of the previous one
    always_comb begin
        tick_d = (clear || load) ? '0 : count_en ? (wrap ? '0 : tick_q + 1'b1) : tick_q;
        unit_d = clear ? 4'd0 : load ? units : (count_en && wrap) ? unit_q - 4'd1 : unit_q;
        lim_d  = clear ? '0 : load ? tick_last : lim_q;
    end

    // counter registers
    always_ff @(posedge clk100M or posedge rst) begin
        if (rst) begin
            tick_q <= '0;
            lim_q  <= '0;
            unit_q <= 4'd0;
        end else begin
            tick_q <= tick_d;
            lim_q  <= lim_d;
            unit_q <= unit_d;
        end
    end

endmodule

// File: rtl/beep_request_scheduler.sv
// beep_request_scheduler: latches beep requests, plays them one at a time in fixed priority with a silent gap
module beep_request_scheduler
    import audio_pkg::*;
#(
    parameter int                   NUM_REQ        = 4,
    parameter int                   TICKS_PER_UNIT = UNIT_100MS,
    parameter int                   GAP_TICKS      = GAP_50MS,
    parameter logic [NUM_REQ-1:0]   TONE_MAP       = '0
) (
    input  logic                        clk100M,
    input  logic                        rst,
    beep_request_scheduler_if.slave     bus
);

    localparam int IDW = cnt_width(NUM_REQ);
    localparam int TW  = cnt_width((TICKS_PER_UNIT > GAP_TICKS) ? TICKS_PER_UNIT : GAP_TICKS);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_UNIT - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);

    if (GAP_TICKS < 1 || TICKS_PER_UNIT < 1) begin : g_param_check
        $error("beep_request_scheduler: GAP_TICKS and TICKS_PER_UNIT must be at least 1");
    end

    state_t                    state_q, state_d;
    logic [NUM_REQ-1:0]        pend_q, pend_d;
    logic [NUM_REQ-1:0][3:0]   len_q, len_d;
    logic [IDW-1:0]            active_q, active_d, g;
    logic                      t_clear, t_load, t_en, t_last_cycle, t_running;
    logic [3:0]                t_units;
    logic [TW-1:0]             t_tick_last;

    beep_unit_timer #(.TW(TW)) u_timer (
        .clk100M    (clk100M),
        .rst        (rst),
        .clear      (t_clear),
        .load       (t_load),
        .units      (t_units),
        .tick_last  (t_tick_last),
        .count_en   (t_en),
        .last_cycle (t_last_cycle),
        .running    (t_running)
    );

    // lowest pending index wins
    always_comb begin
        g = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (pend_q[i]) g = IDW'(i);
    end

    // next state, request capture and timer control; abort overrides everything, captures follow the grant clear
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        len_d       = len_q;
        active_d    = active_q;
        t_clear     = 1'b0;
        t_load      = 1'b0;
        t_en        = 1'b0;
        t_units     = 4'd0;
        t_tick_last = '0;
        if (bus.abort) begin
            state_d = ST_IDLE;
            pend_d  = '0;
            t_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: if (|pend_q) begin
                    state_d     = ST_PLAY;
                    active_d    = g;
                    pend_d[g]   = 1'b0;
                    t_load      = 1'b1;
                    t_units     = len_q[g];
                    t_tick_last = TICK_LAST;
                end
                ST_PLAY: begin
                    t_en = t_running;
                    if (t_last_cycle) begin
                        state_d     = ST_GAP;
                        t_load      = 1'b1;
                        t_units     = 4'd1;
                        t_tick_last = GAP_LAST;
                    end
                end
                ST_GAP: begin
                    t_en = t_running;
                    if (t_last_cycle) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            for (int i = 0; i < NUM_REQ; i++)
                if (bus.req[i] && bus.req_len[4*i +: 4] != 4'd0) begin
                    pend_d[i] = 1'b1;
                    len_d[i]  = bus.req_len[4*i +: 4];
                end
        end
    end

    // scheduler state registers
    always_ff @(posedge clk100M or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pend_q   <= '0;
            len_q    <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            len_q    <= len_d;
            active_q <= active_d;
        end
    end

    assign bus.sound_on  = state_q == ST_PLAY;
    assign bus.busy      = state_q != ST_IDLE;
    assign bus.beep_done = (state_q == ST_PLAY) && t_last_cycle;
    assign bus.active_id = active_q;
    assign bus.audio_out = (state_q == ST_PLAY) ? (TONE_MAP[active_q] ? bus.tone_b : bus.tone_a) : 12'd0;

endmodule

// File: tb/tb_beep_request_scheduler.sv
// tb_beep_request_scheduler: directed stimulus with a beep scoreboard checked by an independent monitor
module tb_beep_request_scheduler;

    localparam logic [11:0] TA = 12'hAAA;
    localparam logic [11:0] TB = 12'hBBB;

    typedef struct {
        int          id;
        int          cycles;
        logic [11:0] audio;
        int          dones;
    } beep_t;

    logic clk100M = 1'b0;
    logic rst     = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    int   done_total = 0;

    beep_t exp_q[$];
    beep_t cur;
    bit    in_beep = 0;
    int    n_cyc, n_done;
    bit    abad;
    logic [11:0] aval;

    beep_request_scheduler_if #(.NUM_REQ(4)) bus();

    beep_request_scheduler #(
        .NUM_REQ(4), .TICKS_PER_UNIT(4), .GAP_TICKS(2), .TONE_MAP(4'b0010)
    ) dut (
        .clk100M (clk100M),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk100M = ~clk100M;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk100M);
        #1;
    endtask

    task automatic pulse(input logic [3:0] mask, input logic [15:0] lens);
        bus.req     = mask;
        bus.req_len = lens;
        tick();
        bus.req     = '0;
        bus.req_len = '0;
    endtask

    task automatic push(input int id, input int cycles, input logic [11:0] audio, input int dones);
        exp_q.push_back('{id: id, cycles: cycles, audio: audio, dones: dones});
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int c = 0; c < 300 && quiet < 3; c++) begin
            tick();
            quiet = bus.busy ? 0 : quiet + 1;
        end
        chk("wait_idle_timeout", 32'(quiet >= 3), 32'd1);
    endtask

    // monitor: each stretch of sound_on is one beep, compared against the head of the scoreboard
    always @(negedge clk100M) begin
        if (bus.sound_on) begin
            if (!in_beep) begin
                in_beep = 1;
                n_cyc = 0;
                n_done = 0;
                abad = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beep id=%0d want=none at %0t", bus.active_id, $time);
                    cur = '{id: 99, cycles: 0, audio: 12'h0, dones: 0};
                end else begin
                    cur = exp_q.pop_front();
                    chk("beep_id", 32'(bus.active_id), 32'(cur.id));
                end
            end
            n_cyc++;
            n_done += int'(bus.beep_done);
            if (!abad) aval = bus.audio_out;
            if (bus.audio_out !== cur.audio) abad = 1;
        end else if (in_beep) begin
            in_beep = 0;
            chk("beep_len", 32'(n_cyc), 32'(cur.cycles));
            chk("beep_done_cnt", 32'(n_done), 32'(cur.dones));
            chk("beep_audio", 32'(aval), 32'(cur.audio));
        end
        done_total += int'(bus.beep_done);
    end

    initial begin
        int d0;
        bus.req = '0;
        bus.req_len = '0;
        bus.abort = 1'b0;
        bus.tone_a = TA;
        bus.tone_b = TB;
        #1;
        chk("rst_sound_on", 32'(bus.sound_on), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_beep_done", 32'(bus.beep_done), 32'd0);
        chk("rst_active_id", 32'(bus.active_id), 32'd0);
        chk("rst_audio", 32'(bus.audio_out), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();

        // single beep with latency and gap timing
        push(0, 12, TA, 1);
        pulse(4'b0001, 16'h0003);
        chk("single_pre_latency", 32'(bus.sound_on), 32'd0);
        tick();
        chk("single_latency", 32'(bus.sound_on), 32'd1);
        repeat (11) tick();
        chk("single_done_last", 32'(bus.beep_done), 32'd1);
        tick();
        chk("single_gap0_snd", 32'(bus.sound_on), 32'd0);
        chk("single_gap0_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("single_gap1_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("single_idle", 32'(bus.busy), 32'd0);
        wait_idle();

        // simultaneous requests 1 and 3
        push(1, 4, TB, 1);
        push(3, 8, TA, 1);
        pulse(4'b1010, 16'h2010);
        repeat (7) tick();
        chk("simul_idle_between", 32'(bus.busy), 32'd0);
        tick();
        chk("simul_second_on", 32'(bus.sound_on), 32'd1);
        chk("simul_second_id", 32'(bus.active_id), 32'd3);
        wait_idle();
        chk("active_id_hold", 32'(bus.active_id), 32'd3);

        // zero length ignored, overwrite while pending
        pulse(4'b0100, 16'h0000);
        tick();
        chk("zero_len_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("zero_len_busy2", 32'(bus.busy), 32'd0);
        push(0, 8, TA, 1);
        push(2, 4, TA, 1);
        pulse(4'b0001, 16'h0002);
        repeat (2) tick();
        pulse(4'b0100, 16'h0200);
        pulse(4'b0100, 16'h0100);
        wait_idle();

        // retrigger from the playing source
        d0 = done_total;
        push(0, 4, TA, 1);
        push(0, 4, TA, 1);
        pulse(4'b0001, 16'h0001);
        tick();
        pulse(4'b0001, 16'h0001);
        wait_idle();
        chk("retrigger_dones", 32'(done_total - d0), 32'd2);

        // abort on the third PLAY cycle with requester 1 pending
        d0 = done_total;
        push(0, 3, TA, 0);
        pulse(4'b0001, 16'h0005);
        tick();
        pulse(4'b0010, 16'h0010);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_sound_off", 32'(bus.sound_on), 32'd0);
        chk("abort_audio", 32'(bus.audio_out), 32'd0);
        chk("abort_no_done", 32'(bus.beep_done), 32'd0);
        wait_idle();
        chk("abort_dones", 32'(done_total - d0), 32'd0);

        // asynchronous reset in the middle of PLAY with requester 2 pending
        push(0, 2, TA, 0);
        pulse(4'b0101, 16'h0103);
        tick();
        tick();
        #5;
        rst = 1'b1;
        #1;
        chk("arst_sound_on", 32'(bus.sound_on), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_audio", 32'(bus.audio_out), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("arst_no_stale", 32'(bus.busy), 32'd0);

        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/beep_request_scheduler.md
Name: beep_request_scheduler

Overview:
- Shares the single audio output between NUM_REQ event sources, e.g. valid-entry, error and game-over beeps.
- Each source pulses a request carrying a 4-bit length in 100 ms units.
- The scheduler latches requests, grants them in fixed priority, times each beep and inserts a silent gap between beeps.
- It muxes the granted source's tone sample (tone_a / tone_b, produced by existing beep generators) onto audio_out. It sits between the game-logic FSMs and the audio DAC driver.

Parameters:
- NUM_REQ, 4, number of requesters. Index 0 has the highest priority.
- TICKS_PER_UNIT, 10_000_000, clk100M cycles per length unit (100 ms).
- GAP_TICKS, 5_000_000, silent cycles forced after every beep (50 ms).
- TONE_MAP, 4'b0000, bit i = 1 selects tone_b for requester i, else tone_a.

Ports:
- clk100M  input  1  system clock, 100 MHz
- rst  input  1  asynchronous active-high reset
- req  input  NUM_REQ  one-cycle request pulses, one bit per requester
- req_len  input  4*NUM_REQ  length for requester i in bits [4i+3:4i], sampled when req[i]=1
- abort  input  1  synchronous flush: silence output, drop all pending requests
- tone_a  input  12  sample stream of tone A (e.g. 200 Hz)
- tone_b  input  12  sample stream of tone B
- audio_out  output  12  tone_a/tone_b sample while playing, else 0
- sound_on  output  1  high exactly while in PLAY
- active_id  output  2  index of the granted requester (log2 NUM_REQ bits)
- busy  output  1  high in PLAY or GAP
- beep_done  output  1  one-cycle pulse on the last PLAY cycle

Behaviour:
- Reset (async, active-high):
  - state=IDLE; all pending bits, stored lengths and counters cleared.
  - sound_on=0, busy=0, beep_done=0, active_id=0, audio_out=0.
- Request capture:
  - req[i]=1 with req_len[i]!=0 sets pending[i] and stores len[i] at the next edge.
  - req_len[i]==0 is ignored.
  - A repeat request while pending[i]=1 overwrites len[i]; no queue depth beyond 1.
  - A request from the currently playing source sets pending[i], so it retriggers after the gap.
- FSM IDLE:
  - If any pending bit is set, grant the lowest index g.
  - Load unit_cnt=len[g], tick_cnt=0, active_id=g, clear pending[g] and go to PLAY.
  - A request arriving in the same cycle as that grant edge is captured; the edge that clears pending[g] does not lose a simultaneous req[g].
- FSM PLAY:
  - sound_on=1, busy=1.
  - tick_cnt counts 0..TICKS_PER_UNIT-1 and wraps; on each wrap unit_cnt decrements.
  - PLAY lasts exactly len*TICKS_PER_UNIT cycles.
  - On the last cycle beep_done=1; the next state is GAP with tick_cnt=0.
- FSM GAP:
  - sound_on=0, busy=1.
  - Holds for exactly GAP_TICKS cycles, then goes to IDLE.
  - IDLE lasts at least 1 cycle before the next grant.
- Latency: a req pulse at edge t gives PLAY (sound_on=1) from edge t+2.
- Output mux: audio_out = sound_on ? (TONE_MAP[active_id] ? tone_b : tone_a) : 12'd0.
  - This is combinational from registered state and tone inputs.
  - No other combinational input-to-output path.
- Registered outputs: sound_on, busy, beep_done and active_id are driven from registered state. active_id holds its value after PLAY until the next grant.
- abort:
  - Has priority over all else at that edge.
  - Goes to IDLE, clears all pending bits and counters; sound_on=0 next cycle.
  - beep_done is not asserted; req in the same cycle is discarded.
- Counter widths: tick_cnt sized as clog2(max(TICKS_PER_UNIT, GAP_TICKS)); unit_cnt is 4 bits, with no overflow possible.
- Parameter rules: TICKS_PER_UNIT ≥ 1 and GAP_TICKS ≥ 1. GAP_TICKS=0 is illegal; check it with an elaboration-time assertion.

Decomposition:
- Shared package audio_pkg:
  - state encoding ST_IDLE=2'd0, ST_PLAY=2'd1, ST_GAP=2'd2.
  - default timing constants: UNIT_100MS=10_000_000, GAP_50MS=5_000_000.
- One natural sub-module, beep_unit_timer: a loadable tick/unit down-counter.
  - Inputs: load, units, count_en.
  - Outputs: last_cycle, running.
  - Used for both the PLAY and GAP phases (GAP loads units=1 with a GAP_TICKS terminal count).
- The priority encoder stays inline.

Test Plan (TICKS_PER_UNIT=4, GAP_TICKS=2, TONE_MAP=4'b0010, tone_a=12'hAAA, tone_b=12'hBBB):
- Single beep:
  - Stimulus: req[0] with len=3 at cycle 10.
  - Response: sound_on=1 for cycles 12–23 with audio_out=AAA; beep_done at 23; busy through 25; IDLE at 26.
- Simultaneous requests:
  - Stimulus: req=4'b1010, len1=1, len3=2.
  - Response: requester 1 plays 4 cycles with audio_out=BBB, then a 2-cycle gap and 1 IDLE cycle, then requester 3 plays 8 cycles with AAA.
- Zero length and overwrite:
  - Stimulus: req[2] with len=0 gives no pending and busy stays 0. While 0 plays, req[2] with len=2 then len=1 follows.
  - Response: requester 2 later plays 4 cycles.
- Retrigger: req[0] len=1 during its own PLAY → a second 4-cycle beep after the gap; total of 2 beep_done pulses.
- Abort mid-beep:
  - Stimulus: abort at cycle 3 of a len=5 beep while req[1] is pending.
  - Response: sound_on=0 and audio_out=0 next cycle, no beep_done; requester 1 never plays.
- Async reset: assert rst mid-PLAY between clock edges → outputs 0 immediately without waiting for a clock edge; after release, no stale pending beep plays.
